// File: rtl/cr16_cond_pkg.sv
// cr16_cond_pkg: shared constants and types for the CR16 condition evaluator.
package cr16_cond_pkg;
  localparam int P_FLAG_WIDTH = 5;
  localparam int P_PEND_WIDTH = 2;
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;
  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_HI, COND_LS, COND_GT, COND_LE,
    COND_FS, COND_FC, COND_LO, COND_HS, COND_LT, COND_GE, COND_UC, COND_NV
  } cond_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/cr16_cond_eval_if.sv
// cr16_cond_eval_if: flag, request and result handshake bundle of the condition evaluator.
interface cr16_cond_eval_if;
  import cr16_cond_pkg::*;
  logic [P_FLAG_WIDTH-1:0] flags;
  logic flag_wr_issue;
  logic flag_wr_retire;
  logic req_valid;
  logic [3:0] cond;
  logic req_ready;
  logic res_valid;
  logic res_ready;
  logic taken;
  logic issue_stall;
  logic proto_err;
  modport master (
    output flags, flag_wr_issue, flag_wr_retire, req_valid, cond, res_ready,
    input  req_ready, res_valid, taken, issue_stall, proto_err
  );
  modport slave (
    input  flags, flag_wr_issue, flag_wr_retire, req_valid, cond, res_ready,
    output req_ready, res_valid, taken, issue_stall, proto_err
  );
endinterface

// File: rtl/cr16_cond_decode.sv
// cr16_cond_decode: combinational condition-code resolver over the {N,Z,F,L,C} flags.
module cr16_cond_decode
  import cr16_cond_pkg::*;
(
  input  logic [3:0]              cond_i,
  input  logic [P_FLAG_WIDTH-1:0] flags_i,
  output logic                    taken_o
);
  logic n, z, f, l, c;
  logic [15:0] tbl;
  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign f = flags_i[FLAG_F];
  assign l = flags_i[FLAG_L];
  assign c = flags_i[FLAG_C];
  // indexed by condition code, NV at the top down to EQ at bit 0
  assign tbl = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                ~n, n, ~l, l, ~c, c, ~z, z};
  assign taken_o = tbl[cond_i];
endmodule

// File: rtl/cr16_cond_eval.sv
// cr16_cond_eval: waits for older flag writers to retire, then resolves a condition code
// and returns the registered result over a valid/ready handshake.
module cr16_cond_eval
  import cr16_cond_pkg::*;
(
  input logic        clk_i,
  input logic        rst_i,
  cr16_cond_eval_if.slave bus
);
  localparam logic [P_PEND_WIDTH-1:0] PEND_MAX = '1;
  state_e state_q, state_d;
  logic [P_PEND_WIDTH-1:0] pend_q, pend_d, wait_q, wait_d;
  logic [3:0] cond_q, cond_d;
  logic taken_q, taken_d, err_q, err_d, eval_taken, inc, dec;
  cr16_cond_decode u_dec (
    .cond_i  (cond_q),
    .flags_i (bus.flags),
    .taken_o (eval_taken)
  );
  assign inc = bus.flag_wr_issue & ~bus.flag_wr_retire;
  assign dec = bus.flag_wr_retire & ~bus.flag_wr_issue;
  always_comb begin
    pend_d = (inc && pend_q != PEND_MAX) ? pend_q + 1'b1 :
             (dec && pend_q != '0)       ? pend_q - 1'b1 : pend_q;
    err_d  = err_q | (inc && pend_q == PEND_MAX) | (dec && pend_q == '0);
  end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        // a writer issued alongside the request is younger and is not waited on
        cond_d  = bus.cond;
        wait_d  = (bus.flag_wr_retire && pend_q != '0) ? pend_q - 1'b1 : pend_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.flag_wr_retire && wait_q != '0) wait_d = wait_q - 1'b1;
        else if (!bus.flag_wr_retire && wait_q == '0) begin
          taken_d = eval_taken;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = bus.res_ready ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      wait_q  <= '0;
      cond_q  <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end
  assign bus.req_ready   = state_q == S_IDLE && !rst_i;
  assign bus.res_valid   = state_q == S_DONE;
  assign bus.taken       = taken_q;
  assign bus.issue_stall = pend_q == PEND_MAX;
  assign bus.proto_err   = err_q;
endmodule

// File: tb/tb_cr16_cond_eval.sv
// tb_cr16_cond_eval: directed and randomized checks of the condition evaluator against a
// table-driven reference and a counting model of outstanding flag writers.
module tb_cr16_cond_eval;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  cr16_cond_eval_if ifc ();
  cr16_cond_eval dut (.clk_i(clk), .rst_i(rst), .bus(ifc));
  always #5 clk = ~clk;

  function automatic logic ref_taken(input int c, input logic [4:0] f);
    logic n, z, ff, l, cc;
    {n, z, ff, l, cc} = f;
    case (c)
      0: return z;         1: return !z;
      2: return cc;        3: return !cc;
      4: return l;         5: return !l;
      6: return n;         7: return !n;
      8: return ff;        9: return !ff;
      10: return !l && !z; 11: return l || z;
      12: return !n && !z; 13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready got %b want 0", ifc.req_ready); end
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", ifc.res_valid); end
    n_cmp++; if (ifc.taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken got %b want 0", ifc.taken); end
    n_cmp++; if (ifc.issue_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", ifc.issue_stall); end
    n_cmp++; if (ifc.proto_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", ifc.proto_err); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready got %b want 1", ifc.req_ready); end
  endtask

  task automatic run_req(input logic [3:0] c, input logic [4:0] f, input string tag);
    logic exp;
    exp = ref_taken(int'(c), f);
    @(negedge clk);
    n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready got %b want 1", tag, ifc.req_ready); end
    ifc.flags = f; ifc.cond = c; ifc.req_valid = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0; ifc.cond = 4'($urandom_range(0, 15));
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL %s_early got %b want 0", tag, ifc.res_valid); end
    @(negedge clk);
    n_cmp++; if (ifc.res_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid got %b want 1", tag, ifc.res_valid); end
    n_cmp++; if (ifc.taken !== exp) begin n_bad++; $display("FAIL %s_taken cond=%0d flags=%b got %b want %b", tag, c, f, ifc.taken, exp); end
    ifc.flags = 5'($urandom_range(0, 31)); ifc.res_ready = 1'b1;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drop got %b want 0", tag, ifc.res_valid); end
  endtask

  task automatic test_basic();
    run_req(4'd0, 5'b01000, "eq_z1");
    run_req(4'd1, 5'b01000, "ne_z1");
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 32; f++)
        run_req(4'(c), 5'(f), "sweep");
  endtask

  task automatic test_writers();
    @(negedge clk); ifc.flag_wr_issue = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ifc.flag_wr_issue = 1'b0; ifc.flags = 5'b10000; ifc.cond = 4'd12; ifc.req_valid = 1'b1;
    n_cmp++; if (ifc.issue_stall !== 1'b0) begin n_bad++; $display("FAIL wr_stall got %b want 0", ifc.issue_stall); end
    @(negedge clk);
    ifc.req_valid = 1'b0; ifc.flag_wr_retire = 1'b1; ifc.flag_wr_issue = 1'b1;
    n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready got %b want 0", ifc.req_ready); end
    @(negedge clk);
    ifc.flag_wr_issue = 1'b0;
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL wr_wait1 got %b want 0", ifc.res_valid); end
    @(negedge clk);
    ifc.flag_wr_retire = 1'b0; ifc.flags = 5'b00000;
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL wr_wait2 got %b want 0", ifc.res_valid); end
    @(negedge clk);
    n_cmp++; if (ifc.res_valid !== 1'b1) begin n_bad++; $display("FAIL wr_valid got %b want 1", ifc.res_valid); end
    n_cmp++; if (ifc.taken !== 1'b1) begin n_bad++; $display("FAIL wr_taken got %b want 1", ifc.taken); end
    ifc.res_ready = 1'b1; ifc.flag_wr_retire = 1'b1;
    @(negedge clk);
    ifc.res_ready = 1'b0; ifc.flag_wr_retire = 1'b0;
    n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_idle got %b want 1", ifc.req_ready); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    ifc.flags = 5'b01000; ifc.cond = 4'd0; ifc.req_valid = 1'b1; ifc.flag_wr_issue = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0; ifc.flag_wr_issue = 1'b0;
    n_cmp++; if (ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL sc_early got %b want 0", ifc.res_valid); end
    @(negedge clk);
    n_cmp++; if (ifc.res_valid !== 1'b1) begin n_bad++; $display("FAIL sc_valid got %b want 1", ifc.res_valid); end
    n_cmp++; if (ifc.taken !== 1'b1) begin n_bad++; $display("FAIL sc_taken got %b want 1", ifc.taken); end
    ifc.flag_wr_retire = 1'b1;
    @(negedge clk);
    ifc.flag_wr_retire = 1'b0; ifc.flags = 5'b00000;
    n_cmp++; if (ifc.taken !== 1'b1) begin n_bad++; $display("FAIL sc_stable got %b want 1", ifc.taken); end
    ifc.res_ready = 1'b1;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    n_cmp++; if (ifc.req_ready !== 1'b1) begin n_bad++; $display("FAIL sc_idle got %b want 1", ifc.req_ready); end
  endtask

  task automatic test_hold();
    logic [3:0] c;
    logic [4:0] f;
    logic exp;
    c = 4'($urandom_range(0, 13)); f = 5'($urandom_range(0, 31)); exp = ref_taken(int'(c), f);
    @(negedge clk);
    ifc.flags = f; ifc.cond = c; ifc.req_valid = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (ifc.res_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got %b want 1", i, ifc.res_valid); end
      n_cmp++; if (ifc.taken !== exp) begin n_bad++; $display("FAIL hold_taken[%0d] got %b want %b", i, ifc.taken, exp); end
      n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d] got %b want 0", i, ifc.req_ready); end
      ifc.flags = ~f;
    end
    ifc.res_ready = 1'b1;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    n_cmp++; if (ifc.req_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", ifc.req_ready, ifc.res_valid); end
  endtask

  task automatic test_random();
    int pend_m = 0, phase = 0, older = 0, cond_m = 0;
    logic exp_t = 1'b0;
    logic iss, ret, rv, rr;
    logic [3:0] c;
    logic [4:0] f;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      n_cmp++; if (ifc.req_ready !== (phase == 0)) begin n_bad++; $display("FAIL rnd_ready cyc=%0d got %b want %b", cyc, ifc.req_ready, phase == 0); end
      n_cmp++; if (ifc.res_valid !== (phase == 2)) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, ifc.res_valid, phase == 2); end
      n_cmp++; if (ifc.issue_stall !== (pend_m == 3)) begin n_bad++; $display("FAIL rnd_stall cyc=%0d got %b want %b", cyc, ifc.issue_stall, pend_m == 3); end
      n_cmp++; if (ifc.proto_err !== 1'b0) begin n_bad++; $display("FAIL rnd_err cyc=%0d got %b want 0", cyc, ifc.proto_err); end
      if (phase == 2) begin
        n_cmp++; if (ifc.taken !== exp_t) begin n_bad++; $display("FAIL rnd_taken cyc=%0d got %b want %b", cyc, ifc.taken, exp_t); end
      end
      iss = pend_m < 3 && $urandom_range(0, 2) == 0;
      ret = pend_m > 0 && $urandom_range(0, 2) == 0;
      rv = 1'($urandom_range(0, 1));
      rr = $urandom_range(0, 2) == 0;
      c = 4'($urandom_range(0, 15));
      f = 5'($urandom_range(0, 31));
      ifc.flag_wr_issue = iss; ifc.flag_wr_retire = ret; ifc.req_valid = rv;
      ifc.res_ready = rr; ifc.cond = c; ifc.flags = f;
      if (phase == 0 && rv) begin
        cond_m = int'(c); older = pend_m - int'(ret); phase = 1;
      end else if (phase == 1) begin
        if (ret && older > 0) older--;
        else if (!ret && older == 0) begin exp_t = ref_taken(cond_m, f); phase = 2; end
      end else if (phase == 2 && rr) phase = 0;
      pend_m += int'(iss) - int'(ret);
    end
    @(negedge clk);
    ifc.flag_wr_issue = 1'b0; ifc.flag_wr_retire = 1'b0; ifc.req_valid = 1'b0; ifc.res_ready = 1'b0;
  endtask

  task automatic test_stall_err();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ifc.flag_wr_issue = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ifc.issue_stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall got %b want 1", ifc.issue_stall); end
    n_cmp++; if (ifc.proto_err !== 1'b0) begin n_bad++; $display("FAIL sat_err_early got %b want 0", ifc.proto_err); end
    @(negedge clk);
    n_cmp++; if (ifc.issue_stall !== 1'b1) begin n_bad++; $display("FAIL ovf_stall got %b want 1", ifc.issue_stall); end
    n_cmp++; if (ifc.proto_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b want 1", ifc.proto_err); end
    ifc.flag_wr_issue = 1'b0; ifc.flag_wr_retire = 1'b1;
    @(negedge clk);
    ifc.flag_wr_retire = 1'b0;
    n_cmp++; if (ifc.issue_stall !== 1'b0) begin n_bad++; $display("FAIL ovf_hold3 got stall=%b want 0", ifc.issue_stall); end
    n_cmp++; if (ifc.proto_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", ifc.proto_err); end
    ifc.cond = 4'd14; ifc.req_valid = 1'b1;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    n_cmp++; if (ifc.res_valid !== 1'b0 || ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_wait got valid=%b ready=%b want 0/0", ifc.res_valid, ifc.req_ready); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ifc.req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", ifc.req_ready); end
    n_cmp++; if (ifc.taken !== 1'b0) begin n_bad++; $display("FAIL rst_taken got %b want 0", ifc.taken); end
    n_cmp++; if (ifc.proto_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", ifc.proto_err); end
    n_cmp++; if (ifc.issue_stall !== 1'b0 || ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_misc got stall=%b valid=%b want 0/0", ifc.issue_stall, ifc.res_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.req_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release got ready=%b valid=%b want 1/0", ifc.req_ready, ifc.res_valid); end
  endtask

  initial begin
    rst = 1'b1;
    ifc.flags = '0; ifc.flag_wr_issue = 1'b0; ifc.flag_wr_retire = 1'b0;
    ifc.req_valid = 1'b0; ifc.cond = '0; ifc.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_sweep();
    test_writers();
    test_same_cycle();
    test_hold();
    test_random();
    test_stall_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d compared", n_cmp);
    $fatal(1);
  end
endmodule
